// File: rtl/serial_adder_ctrl.sv
// serial_adder_ctrl: bit-serial add sequencer.
// One 1-bit full adder is reused over WIDTH clocks, LSB first. The result is
// {cout,sum} = a + b + cin.
//
// Ports:
//   clk, rst_n          clock; synchronous active-low reset
//   in_valid/in_ready   operand handshake; in_ready is high only in IDLE
//   a, b, cin           operands; captured on the accept edge
//   out_valid/out_ready result handshake; out_valid is high only in DONE
//   sum, cout           result; held stable while in DONE
//   busy                high while in RUN or DONE
module serial_adder_ctrl #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             busy
);

  localparam int CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(WIDTH - 1);

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    RUN  = 2'b01,
    DONE = 2'b10
  } state_t;

  state_t           state;
  state_t           state_nx;
  logic [CNT_W-1:0] cnt;
  logic [WIDTH-1:0] a_sh;
  logic [WIDTH-1:0] b_sh;
  logic [WIDTH-1:0] sum_r;
  logic             carry;
  logic             cout_r;
  logic             fa_sum;
  logic             fa_carry;
  logic             last_bit;

  // The shared 1-bit adder slice.
  assign fa_sum   = a_sh[0] ^ b_sh[0] ^ carry;
  assign fa_carry = (a_sh[0] & b_sh[0]) | (a_sh[0] & carry) | (b_sh[0] & carry);
  assign last_bit = (cnt == LAST);

  always_ff @(posedge clk) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nx;
  end

  always_comb begin
    state_nx  = state;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    busy      = 1'b0;
    case (state)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) state_nx = RUN;
      end
      RUN: begin
        busy = 1'b1;
        if (last_bit) state_nx = DONE;
      end
      DONE: begin
        busy      = 1'b1;
        out_valid = 1'b1;
        if (out_ready) state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt    <= '0;
      a_sh   <= '0;
      b_sh   <= '0;
      sum_r  <= '0;
      carry  <= 1'b0;
      cout_r <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            a_sh  <= a;
            b_sh  <= b;
            carry <= cin;
            cnt   <= '0;
          end
        end
        RUN: begin
          carry <= fa_carry;
          // The new sum bit enters at the MSB. Taking the shift through a
          // WIDTH+1 vector keeps this legal when WIDTH is 1.
          sum_r <= WIDTH'({fa_sum, sum_r} >> 1);
          a_sh  <= a_sh >> 1;
          b_sh  <= b_sh >> 1;
          // The counter wraps to 0 on the last bit, so it stays 0 when WIDTH is 1.
          cnt   <= last_bit ? '0 : cnt + CNT_W'(1);
          if (last_bit) cout_r <= fa_carry;
        end
        default: ;
      endcase
    end
  end

  assign sum  = sum_r;
  assign cout = cout_r;

endmodule

// File: tb/tb_serial_adder_ctrl.sv
module tb_serial_adder_ctrl;

  logic       clk = 1'b0;
  logic       rst_n8, in_valid8, in_ready8, cin8, out_valid8, out_ready8, cout8, busy8;
  logic [7:0] a8, b8, sum8;
  logic       rst_n1, in_valid1, in_ready1, cin1, out_valid1, out_ready1, cout1, busy1;
  logic [0:0] a1, b1, sum1;

  int n_chk = 0;
  int n_err = 0;
  int unsigned edges = 0;
  logic [8:0] sb[$];

  always #5 clk = ~clk;
  always @(posedge clk) edges <= edges + 1;

  serial_adder_ctrl #(.WIDTH(8)) u_dut8 (
    .clk(clk), .rst_n(rst_n8), .in_valid(in_valid8), .in_ready(in_ready8),
    .a(a8), .b(b8), .cin(cin8), .out_valid(out_valid8), .out_ready(out_ready8),
    .sum(sum8), .cout(cout8), .busy(busy8)
  );

  serial_adder_ctrl #(.WIDTH(1)) u_dut1 (
    .clk(clk), .rst_n(rst_n1), .in_valid(in_valid1), .in_ready(in_ready1),
    .a(a1), .b(b1), .cin(cin1), .out_valid(out_valid1), .out_ready(out_ready1),
    .sum(sum1), .cout(cout1), .busy(busy1)
  );

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // Scoreboard for the WIDTH=8 instance: push the reference on accept, pop on delivery.
  always @(negedge clk) begin
    if (!rst_n8) begin
      sb.delete();
    end else begin
      if (in_valid8 && in_ready8)
        sb.push_back({1'b0, a8} + {1'b0, b8} + {8'd0, cin8});
      if (out_valid8 && out_ready8) begin
        if (sb.size() == 0) chk("sb_unexpected_result", 32'd1, 32'd0);
        else chk("sb_result", {23'd0, cout8, sum8}, {23'd0, sb.pop_front()});
      end
    end
  end

  // Called #1 after a posedge; returns #1 after the accept edge.
  task automatic start8(input logic [7:0] av, input logic [7:0] bv, input logic cv);
    int k;
    a8 = av; b8 = bv; cin8 = cv; in_valid8 = 1'b1;
    k = 0;
    @(negedge clk);
    while (!in_ready8 && k < 50) begin
      @(negedge clk);
      k++;
    end
    if (!in_ready8) chk("accept_timeout", 32'd0, 32'd1);
    @(posedge clk); #1;
    in_valid8 = 1'b0;
    a8 = 8'($urandom); b8 = 8'($urandom); cin8 = 1'($urandom);
  endtask

  task automatic wait_done8(output int lat);
    lat = 0;
    while (!out_valid8 && lat < 100) begin
      @(posedge clk); #1;
      lat++;
    end
    if (!out_valid8) chk("done_timeout", 32'd0, 32'd1);
  endtask

  typedef struct {
    logic [7:0] a;
    logic [7:0] b;
    logic       cin;
    logic [7:0] s;
    logic       co;
  } vec_t;

  vec_t vecs[8];

  initial begin
    int lat, k;
    int unsigned acc, prev_acc;
    logic [1:0] r;

    vecs[0] = '{8'h5A, 8'h3C, 1'b0, 8'h96, 1'b0};
    vecs[1] = '{8'hFF, 8'h01, 1'b0, 8'h00, 1'b1};
    vecs[2] = '{8'hFF, 8'hFF, 1'b1, 8'hFF, 1'b1};
    vecs[3] = '{8'h01, 8'h01, 1'b0, 8'h02, 1'b0};
    vecs[4] = '{8'h80, 8'h80, 1'b1, 8'h01, 1'b1};
    vecs[5] = '{8'h00, 8'h00, 1'b1, 8'h01, 1'b0};
    vecs[6] = '{8'h7F, 8'h01, 1'b0, 8'h80, 1'b0};
    vecs[7] = '{8'hA5, 8'h5A, 1'b0, 8'hFF, 1'b0};

    rst_n8 = 0; in_valid8 = 0; a8 = 0; b8 = 0; cin8 = 0; out_ready8 = 0;
    rst_n1 = 0; in_valid1 = 0; a1 = 0; b1 = 0; cin1 = 0; out_ready1 = 0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_in_ready", {31'd0, in_ready8}, 32'd1);
    chk("rst_out_valid", {31'd0, out_valid8}, 32'd0);
    chk("rst_sum", {24'd0, sum8}, 32'd0);
    chk("rst_cout", {31'd0, cout8}, 32'd0);
    chk("rst_busy", {31'd0, busy8}, 32'd0);
    chk("rst1_in_ready", {31'd0, in_ready1}, 32'd1);
    rst_n8 = 1; rst_n1 = 1;

    // Table of single operations with out_ready held high.
    out_ready8 = 1;
    for (int i = 0; i < 8; i++) begin
      start8(vecs[i].a, vecs[i].b, vecs[i].cin);
      chk("busy_run", {31'd0, busy8}, 32'd1);
      chk("in_ready_run", {31'd0, in_ready8}, 32'd0);
      wait_done8(lat);
      chk("latency8", lat, 32'd8);
      chk("vec_sum", {24'd0, sum8}, {24'd0, vecs[i].s});
      chk("vec_cout", {31'd0, cout8}, {31'd0, vecs[i].co});
      @(posedge clk); #1;
      chk("in_ready_after", {31'd0, in_ready8}, 32'd1);
    end

    // Backpressure: hold DONE for 5 cycles; a new request must be ignored.
    out_ready8 = 0;
    start8(8'h12, 8'h34, 1'b0);
    wait_done8(lat);
    for (int i = 0; i < 5; i++) begin
      in_valid8 = 1; a8 = 8'h11; b8 = 8'h11;
      @(posedge clk); #1;
      chk("bp_out_valid", {31'd0, out_valid8}, 32'd1);
      chk("bp_sum", {24'd0, sum8}, 32'h46);
      chk("bp_cout", {31'd0, cout8}, 32'd0);
      chk("bp_in_ready", {31'd0, in_ready8}, 32'd0);
    end
    in_valid8 = 0;
    out_ready8 = 1;
    @(posedge clk); #1;
    chk("bp_release_idle", {31'd0, in_ready8}, 32'd1);
    chk("bp_release_ov", {31'd0, out_valid8}, 32'd0);
    start8(8'h0F, 8'hF0, 1'b1);
    wait_done8(lat);
    chk("bp_next_sum", {23'd0, cout8, sum8}, 32'h100);
    @(posedge clk); #1;

    // Reset after 3 bits of RUN aborts the operation.
    start8(8'hAB, 8'hCD, 1'b0);
    repeat (3) @(posedge clk);
    #1;
    rst_n8 = 0;
    @(posedge clk); #1;
    rst_n8 = 1;
    chk("mid_rst_in_ready", {31'd0, in_ready8}, 32'd1);
    chk("mid_rst_out_valid", {31'd0, out_valid8}, 32'd0);
    chk("mid_rst_sum", {24'd0, sum8}, 32'd0);
    chk("mid_rst_cout", {31'd0, cout8}, 32'd0);
    chk("mid_rst_busy", {31'd0, busy8}, 32'd0);
    start8(8'h01, 8'h01, 1'b0);
    wait_done8(lat);
    chk("post_rst_sum", {23'd0, cout8, sum8}, 32'h002);
    @(posedge clk); #1;

    // Back-to-back: in_valid held high; accepts WIDTH+2 edges apart.
    out_ready8 = 1;
    in_valid8 = 1;
    prev_acc = 0;
    for (int i = 0; i < 4; i++) begin
      a8 = 8'($urandom); b8 = 8'($urandom); cin8 = 1'($urandom);
      k = 0;
      @(negedge clk);
      while (!in_ready8 && k < 50) begin
        @(negedge clk);
        k++;
      end
      if (!in_ready8) chk("b2b_accept_timeout", 32'd0, 32'd1);
      @(posedge clk);
      acc = edges;
      #1;
      if (i > 0) chk("b2b_spacing", acc - prev_acc, 32'd10);
      prev_acc = acc;
    end
    in_valid8 = 0;
    k = 0;
    while (sb.size() != 0 && k < 100) begin
      @(posedge clk); #1;
      k++;
    end
    chk("b2b_drained", sb.size(), 32'd0);

    // WIDTH=1: all eight operand combinations, two-cycle latency.
    out_ready1 = 1;
    for (int v = 0; v < 8; v++) begin
      a1 = v[0]; b1 = v[1]; cin1 = v[2];
      in_valid1 = 1;
      @(negedge clk);
      chk("w1_in_ready", {31'd0, in_ready1}, 32'd1);
      @(posedge clk); #1;
      in_valid1 = 0;
      r = {1'b0, v[0]} + {1'b0, v[1]} + {1'b0, v[2]};
      a1 = 1'($urandom); b1 = 1'($urandom); cin1 = 1'($urandom);
      lat = 0;
      while (!out_valid1 && lat < 20) begin
        @(posedge clk); #1;
        lat++;
      end
      chk("w1_latency", lat, 32'd1);
      chk("w1_result", {30'd0, cout1, sum1}, {30'd0, r});
      @(posedge clk); #1;
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_chk, n_err);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, %0d miscompares so far", n_err);
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/serial_adder_ctrl.md
Name: serial_adder_ctrl

Overview:
Bit-serial add sequencer. It time-shares a single 1-bit full adder (sum = a^b^c, carry = majority) across a WIDTH-bit operation, one bit per clock, LSB first. It accepts operands through a valid/ready input handshake. It returns the sum and carry-out through a valid/ready output handshake. It sits between a requester and the shared 1-bit adder slice, trading latency for area.

Parameters:
WIDTH, 8, operand/sum width in bits; legal range 1..32.
CNT_W, derived as $clog2(WIDTH) (minimum 1), bit-counter width; localparam, not overridable.

Ports:
clk  input  1  rising-edge clock; the only clock.
rst_n  input  1  synchronous reset, active-low; sampled on the clk rising edge.
in_valid  input  1  a, b and cin are valid.
in_ready  output  1  block can accept an operation; high only in IDLE.
a  input  WIDTH  addend 0.
b  input  WIDTH  addend 1.
cin  input  1  carry into bit 0.
out_valid  output  1  sum/cout valid; high only in DONE.
out_ready  input  1  consumer accepts the result.
sum  output  WIDTH  result bits [WIDTH-1:0].
cout  output  1  carry out of bit WIDTH-1.
busy  output  1  high in RUN or DONE.

Behaviour:
- Reset (rst_n=0 at a clk edge), regardless of state:
  - state goes to IDLE; bit counter, operand shift regs, sum and carry regs clear to 0.
  - Outputs after the reset edge: in_ready=1, out_valid=0, sum=0, cout=0, busy=0.
  - Reset mid-RUN or mid-DONE aborts the operation; no result is emitted.
- FSM states: IDLE, RUN, DONE (binary encoded). The encoding 2'b11 is unreachable and must recover to IDLE.
- IDLE:
  - in_ready=1.
  - On in_valid&&in_ready at an edge: load a_sh<=a, b_sh<=b, carry<=cin, cnt<=0; go to RUN.
  - sum/cout keep their previous values (they are not cleared on accept).
- RUN, one bit per cycle:
  - Full adder inputs are a_sh[0], b_sh[0] and carry.
  - On each edge: carry<=fa_carry; sum<={fa_sum, sum[WIDTH-1:1]} (sum bit enters at the MSB and shifts right); a_sh and b_sh shift right by 1; cnt<=cnt+1.
  - When cnt==WIDTH-1 at the edge: cout<=fa_carry; go to DONE.
  - Exactly WIDTH cycles are spent in RUN.
- DONE:
  - out_valid=1; sum and cout are held stable until accepted.
  - On out_ready at an edge: go to IDLE.
  - out_ready held low means stay in DONE indefinitely (backpressure).
- Latency: accept edge at cycle T; out_valid is high starting cycle T+WIDTH+1.
- Minimum issue interval: WIDTH+2 cycles. There is no same-cycle DONE->accept; one bubble in IDLE is required.
- in_valid in RUN/DONE is ignored; inputs are not sampled and in_ready=0.
- out_ready in IDLE/RUN is ignored.
- a, b and cin may change freely after the accept edge; operands are captured.
- Arithmetic: {cout,sum} == a + b + cin, modulo 2^(WIDTH+1); no overflow flag.
- WIDTH=1: RUN lasts one cycle; cnt stays 0.
- All outputs are registered or decoded directly from state; no combinational input-to-output path.

Test Plan:
- WIDTH=8: a=0x5A, b=0x3C, cin=0, out_ready=1 -> out_valid rises exactly 9 cycles after the accept edge; sum=0x96, cout=0; in_ready returns 1 the cycle after the handshake.
- WIDTH=8: a=0xFF, b=0x01, cin=0 -> sum=0x00, cout=1. Then a=0xFF, b=0xFF, cin=1 -> sum=0xFF, cout=1.
- Backpressure: out_ready=0 for 5 cycles in DONE -> out_valid, sum and cout are stable; in_ready=0. A new in_valid with a=0x11 is ignored. Raising out_ready -> IDLE, and the next op completes correctly.
- Reset mid-RUN: assert rst_n=0 for 1 cycle after 3 bits -> next cycle in_ready=1, out_valid=0, sum=0, cout=0, busy=0. A following op 0x01+0x01 gives 0x02, cout=0.
- Back-to-back: in_valid held high with 4 different operand sets, out_ready=1 -> each result matches the reference model; accepts are spaced WIDTH+2 cycles apart.
- WIDTH=1: exhaustive 8 combinations of a, b, cin -> {cout,sum} == a+b+cin; latency 2 cycles.
